// File: rtl/pid_controller_if.sv
// ============================================================================
//  Module      : pid_controller_if
//  Description : Command, feedback and PWM signal bundle for pid_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pid_controller_if;
    logic [11:0] target_angle;
    logic [11:0] current_angle;
    logic        pwm_enable;
    logic        pwm_done;
    logic        i2c_rd_done;
    logic        angle_update;
    logic        abort_angle;
    logic [63:0] profile;
    logic        enable_stall_chk;
    logic [7:0]  kp;
    logic [3:0]  ki;
    logic [3:0]  kd;
    logic        startup_fail;
    logic        angle_done;
    logic        pwm_update;
    logic [7:0]  pwm_ratio;
    logic        pwm_direction;
    logic [15:0] debug_signals;

    modport master (
        output target_angle, current_angle, pwm_enable, pwm_done, i2c_rd_done,
               angle_update, abort_angle, profile, enable_stall_chk, kp, ki, kd,
        input  startup_fail, angle_done, pwm_update, pwm_ratio, pwm_direction,
               debug_signals
    );

    modport slave (
        input  target_angle, current_angle, pwm_enable, pwm_done, i2c_rd_done,
               angle_update, abort_angle, profile, enable_stall_chk, kp, ki, kd,
        output startup_fail, angle_done, pwm_update, pwm_ratio, pwm_direction,
               debug_signals
    );
endinterface

`default_nettype wire

// File: rtl/pid_controller.sv
// ============================================================================
//  Module      : pid_controller
//  Description : Angle PID loop driving a PWM stage, with startup duty profile
//                and stall detection.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pid_controller (
    input  wire logic        clock,
    input  wire logic        reset_n,
    pid_controller_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CALC   = 3'd1,
        S_UPDATE = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic signed [13:0] c_E_MAX   = 14'sd2047;
    localparam logic signed [13:0] c_E_MIN   = -14'sd2048;
    localparam logic signed [13:0] c_E_WRAP  = 14'sd4096;
    localparam logic signed [14:0] c_ACC_MAX = 15'sd4095;
    localparam logic signed [14:0] c_ACC_MIN = -15'sd4096;

    state_t             r_state;
    logic [11:0]        r_target;
    logic [11:0]        r_current;
    logic signed [14:0] r_acc;
    logic signed [13:0] r_e_prev;
    logic [3:0]         r_step;
    logic [2:0]         r_stall;
    logic [7:0]         r_duty;
    logic               r_dir;
    logic [5:0]         r_abs_e;
    logic [7:0]         r_pwm_ratio;
    logic               r_pwm_direction;
    logic               r_pwm_update;
    logic               r_angle_done;
    logic               r_startup_fail;
    logic [15:0]        r_debug;

    logic signed [13:0] w_e_raw;
    logic signed [13:0] w_e;
    logic signed [14:0] w_acc_sum;
    logic signed [14:0] w_acc_new;
    logic signed [14:0] w_diff;
    logic signed [23:0] w_u;
    logic signed [23:0] w_u_shift;
    logic [23:0]        w_mag;
    logic [7:0]         w_duty_sat;
    logic [7:0]         w_cap;
    logic [7:0]         w_duty;
    logic               w_dir;
    logic [5:0]         w_abs_e;
    logic               w_startup;
    logic               w_same;
    logic               w_stall_hit;

    assign w_e_raw = $signed({2'b00, r_target}) - $signed({2'b00, r_current});

    // Fold the raw difference into the shortest way round the encoder circle.
    always_comb begin
        w_e = w_e_raw;
        if (w_e_raw > c_E_MAX)
            w_e = w_e_raw - c_E_WRAP;
        else if (w_e_raw < c_E_MIN)
            w_e = w_e_raw + c_E_WRAP;
    end

    assign w_acc_sum = r_acc + 15'(w_e);

    always_comb begin
        w_acc_new = w_acc_sum;
        if (w_acc_sum > c_ACC_MAX)
            w_acc_new = c_ACC_MAX;
        else if (w_acc_sum < c_ACC_MIN)
            w_acc_new = c_ACC_MIN;
    end

    assign w_diff    = 15'(w_e) - 15'(r_e_prev);
    assign w_u       = 24'($signed({1'b0, bus.kp})) * 24'(w_e)
                     + 24'($signed({1'b0, bus.ki})) * 24'(w_acc_new)
                     + 24'($signed({1'b0, bus.kd})) * 24'(w_diff);
    assign w_u_shift = w_u >>> 4;
    assign w_dir     = ~w_u_shift[23];
    assign w_mag     = w_u_shift[23] ? 24'(-w_u_shift) : 24'(w_u_shift);
    assign w_duty_sat = (w_mag > 24'd255) ? 8'hFF : w_mag[7:0];
    // Low six bits of |e| only depend on the low six bits of e.
    assign w_abs_e   = w_e[13] ? (6'd0 - w_e[5:0]) : w_e[5:0];
    assign w_startup = (r_step < 4'd8);

    always_comb begin
        w_cap = bus.profile[63:56];
        case (r_step[2:0])
            3'd0: w_cap = bus.profile[63:56];
            3'd1: w_cap = bus.profile[55:48];
            3'd2: w_cap = bus.profile[47:40];
            3'd3: w_cap = bus.profile[39:32];
            3'd4: w_cap = bus.profile[31:24];
            3'd5: w_cap = bus.profile[23:16];
            3'd6: w_cap = bus.profile[15:8];
            default: w_cap = bus.profile[7:0];
        endcase
    end

    assign w_duty      = (w_startup && (w_cap < w_duty_sat)) ? w_cap : w_duty_sat;
    assign w_same      = (bus.current_angle == r_current);
    assign w_stall_hit = bus.enable_stall_chk && w_startup && w_same && (r_stall == 3'd3);

    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            r_state         <= S_IDLE;
            r_target        <= '0;
            r_current       <= '0;
            r_acc           <= '0;
            r_e_prev        <= '0;
            r_step          <= '0;
            r_stall         <= '0;
            r_duty          <= '0;
            r_dir           <= 1'b0;
            r_abs_e         <= '0;
            r_pwm_ratio     <= '0;
            r_pwm_direction <= 1'b0;
            r_pwm_update    <= 1'b0;
            r_angle_done    <= 1'b0;
            r_startup_fail  <= 1'b0;
            r_debug         <= '0;
        end else begin
            r_pwm_update <= 1'b0;
            r_angle_done <= 1'b0;
            r_debug      <= {r_abs_e, bus.pwm_done, r_pwm_direction, r_startup_fail,
                             r_step, r_state};
            if (r_state == S_IDLE) begin
                if (bus.angle_update && bus.pwm_enable) begin
                    r_target       <= bus.target_angle;
                    r_current      <= bus.current_angle;
                    r_acc          <= '0;
                    r_e_prev       <= '0;
                    r_step         <= '0;
                    r_stall        <= '0;
                    r_startup_fail <= 1'b0;
                    r_state        <= S_CALC;
                end
            end else if (bus.abort_angle || !bus.pwm_enable) begin
                r_pwm_ratio  <= '0;
                r_pwm_update <= 1'b1;
                r_state      <= S_IDLE;
            end else if (bus.angle_update) begin
                r_target <= bus.target_angle;
                r_step   <= '0;
                r_state  <= S_CALC;
            end else begin
                case (r_state)
                    S_CALC: begin
                        r_abs_e <= w_abs_e;
                        if (w_e == 14'sd0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_acc    <= w_acc_new;
                            r_e_prev <= w_e;
                            r_duty   <= w_duty;
                            r_dir    <= w_dir;
                            r_state  <= S_UPDATE;
                        end
                    end
                    S_UPDATE: begin
                        r_pwm_ratio     <= r_duty;
                        r_pwm_direction <= r_dir;
                        r_pwm_update    <= 1'b1;
                        r_state         <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (bus.i2c_rd_done) begin
                            if (w_stall_hit) begin
                                r_startup_fail <= 1'b1;
                                r_pwm_ratio    <= '0;
                                r_pwm_update   <= 1'b1;
                                r_state        <= S_IDLE;
                            end else begin
                                if (w_startup)
                                    r_step <= r_step + 4'd1;
                                if (bus.enable_stall_chk && w_startup)
                                    r_stall <= w_same ? r_stall + 3'd1 : 3'd0;
                                r_current <= bus.current_angle;
                                r_state   <= S_CALC;
                            end
                        end
                    end
                    S_DONE: begin
                        r_pwm_ratio  <= '0;
                        r_pwm_update <= 1'b1;
                        r_angle_done <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.startup_fail  = r_startup_fail;
    assign bus.angle_done    = r_angle_done;
    assign bus.pwm_update    = r_pwm_update;
    assign bus.pwm_ratio     = r_pwm_ratio;
    assign bus.pwm_direction = r_pwm_direction;
    assign bus.debug_signals = r_debug;
endmodule

`default_nettype wire

// File: tb/tb_pid_controller.sv
// ============================================================================
//  Module      : tb_pid_controller
//  Description : Directed vector bench for pid_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pid_controller;
    logic clock;
    logic reset_n;

    pid_controller_if bus ();

    pid_controller u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [11:0] tgt;
        logic [11:0] cur;
        logic [7:0]  kp;
        logic [3:0]  ki;
        logic [3:0]  kd;
        logic [63:0] prof;
        logic [7:0]  exp_ratio;
        logic        exp_dir;
    } vec_t;

    localparam logic [63:0] c_PROF_RAMP = 64'h0203040506070809;
    localparam logic [63:0] c_PROF_OPEN = 64'hFFFFFFFFFFFFFFFF;

    vec_t vecs[10];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_update(input string name, output int n);
        n = 0;
        while (bus.pwm_update !== 1'b1 && n < 30) begin
            @(negedge clock);
            n++;
        end
        check({name, "_pulse"}, 64'(bus.pwm_update), 64'd1);
    endtask

    task automatic start_move(input logic [11:0] tgt, input logic [11:0] cur);
        bus.target_angle  = tgt;
        bus.current_angle = cur;
        bus.angle_update  = 1'b1;
        @(negedge clock);
        bus.angle_update  = 1'b0;
    endtask

    task automatic do_read(input logic [11:0] cur);
        bus.current_angle = cur;
        bus.i2c_rd_done   = 1'b1;
        @(negedge clock);
        bus.i2c_rd_done   = 1'b0;
    endtask

    task automatic do_abort(input string name);
        int n;
        bus.abort_angle = 1'b1;
        @(negedge clock);
        bus.abort_angle = 1'b0;
        wait_update(name, n);
        check({name, "_ratio"}, 64'(bus.pwm_ratio), 64'd0);
        check({name, "_done"}, 64'(bus.angle_done), 64'd0);
        @(negedge clock);
        check({name, "_single"}, 64'(bus.pwm_update), 64'd0);
        @(negedge clock);
        check({name, "_idle"}, 64'(bus.debug_signals[2:0]), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt;
        vecs[0] = '{12'd100,  12'd10,   8'h12, 4'd0, 4'd0, c_PROF_RAMP, 8'd2,   1'b1};
        vecs[1] = '{12'd10,   12'd4090, 8'h12, 4'd0, 4'd0, c_PROF_OPEN, 8'd18,  1'b1};
        vecs[2] = '{12'd4090, 12'd10,   8'h12, 4'd0, 4'd0, c_PROF_OPEN, 8'd18,  1'b0};
        vecs[3] = '{12'd2000, 12'd0,    8'h10, 4'd0, 4'd0, c_PROF_OPEN, 8'd255, 1'b1};
        vecs[4] = '{12'd0,    12'd2048, 8'h01, 4'd0, 4'd0, c_PROF_OPEN, 8'd128, 1'b0};
        vecs[5] = '{12'd2048, 12'd0,    8'h01, 4'd0, 4'd0, c_PROF_OPEN, 8'd128, 1'b0};
        vecs[6] = '{12'd50,   12'd40,   8'h10, 4'd4, 4'd2, c_PROF_OPEN, 8'd13,  1'b1};
        vecs[7] = '{12'd40,   12'd50,   8'h10, 4'd4, 4'd2, c_PROF_OPEN, 8'd14,  1'b0};
        vecs[8] = '{12'd300,  12'd0,    8'h20, 4'd0, 4'd0, 64'h40FFFFFFFFFFFFFF, 8'd64, 1'b1};
        vecs[9] = '{12'd4095, 12'd0,    8'h10, 4'd0, 4'd0, c_PROF_OPEN, 8'd1,   1'b0};

        reset_n              = 1'b1;
        bus.target_angle     = '0;
        bus.current_angle    = '0;
        bus.pwm_enable       = 1'b1;
        bus.pwm_done         = 1'b0;
        bus.i2c_rd_done      = 1'b0;
        bus.angle_update     = 1'b0;
        bus.abort_angle      = 1'b0;
        bus.profile          = c_PROF_RAMP;
        bus.enable_stall_chk = 1'b0;
        bus.kp               = 8'h12;
        bus.ki               = 4'd0;
        bus.kd               = 4'd0;
        repeat (3) @(negedge clock);
        check("rst_ratio", 64'(bus.pwm_ratio), 64'd0);
        check("rst_dir", 64'(bus.pwm_direction), 64'd0);
        check("rst_update", 64'(bus.pwm_update), 64'd0);
        check("rst_done", 64'(bus.angle_done), 64'd0);
        check("rst_fail", 64'(bus.startup_fail), 64'd0);
        check("rst_debug", 64'(bus.debug_signals), 64'd0);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);

        // Single-step vectors: first update of a move, then abort.
        for (int i = 0; i < 10; i++) begin
            bus.kp      = vecs[i].kp;
            bus.ki      = vecs[i].ki;
            bus.kd      = vecs[i].kd;
            bus.profile = vecs[i].prof;
            start_move(vecs[i].tgt, vecs[i].cur);
            wait_update($sformatf("vec%0d", i), n);
            check($sformatf("vec%0d_ratio", i), 64'(bus.pwm_ratio), 64'(vecs[i].exp_ratio));
            check($sformatf("vec%0d_dir", i), 64'(bus.pwm_direction), 64'(vecs[i].exp_dir));
            do_abort($sformatf("vec%0d_abort", i));
        end

        // Full move with startup profile, then arrival.
        bus.kp = 8'h12; bus.ki = 4'd0; bus.kd = 4'd0; bus.profile = c_PROF_RAMP;
        start_move(12'd100, 12'd10);
        wait_update("move_start", n);
        check("move_start_latency", 64'(n), 64'd2);
        check("move_start_ratio", 64'(bus.pwm_ratio), 64'd2);
        check("move_start_dir", 64'(bus.pwm_direction), 64'd1);
        check("move_start_dbg_abs_e", 64'(bus.debug_signals[15:10]), 64'd26);
        for (int k = 1; k <= 8; k++) begin
            do_read(12'(10 + k));
            wait_update($sformatf("move_read%0d", k), n);
            check($sformatf("move_read%0d_latency", k), 64'(n), 64'd2);
            check($sformatf("move_read%0d_ratio", k), 64'(bus.pwm_ratio),
                  (k < 8) ? 64'(k + 2) : 64'd92);
        end
        do_read(12'd100);
        wait_update("arrive", n);
        check("arrive_ratio", 64'(bus.pwm_ratio), 64'd0);
        check("arrive_done", 64'(bus.angle_done), 64'd1);
        @(negedge clock);
        check("arrive_update_single", 64'(bus.pwm_update), 64'd0);
        check("arrive_done_single", 64'(bus.angle_done), 64'd0);
        @(negedge clock);
        check("arrive_dbg_state", 64'(bus.debug_signals[2:0]), 64'd0);
        check("arrive_dbg_step", 64'(bus.debug_signals[6:3]), 64'd8);

        // Zero error completes immediately.
        start_move(12'd500, 12'd500);
        wait_update("zero_err", n);
        check("zero_err_done", 64'(bus.angle_done), 64'd1);
        check("zero_err_ratio", 64'(bus.pwm_ratio), 64'd0);
        repeat (2) @(negedge clock);

        // Stall detection during startup.
        bus.enable_stall_chk = 1'b1;
        bus.profile = c_PROF_OPEN;
        start_move(12'd100, 12'd10);
        wait_update("stall_start", n);
        check("stall_start_ratio", 64'(bus.pwm_ratio), 64'd101);
        for (int k = 1; k <= 3; k++) begin
            do_read(12'd10);
            wait_update($sformatf("stall_read%0d", k), n);
            check($sformatf("stall_read%0d_ratio", k), 64'(bus.pwm_ratio), 64'd101);
        end
        check("stall_not_yet", 64'(bus.startup_fail), 64'd0);
        do_read(12'd10);
        wait_update("stall_trip", n);
        check("stall_trip_fail", 64'(bus.startup_fail), 64'd1);
        check("stall_trip_ratio", 64'(bus.pwm_ratio), 64'd0);
        check("stall_trip_done", 64'(bus.angle_done), 64'd0);
        @(negedge clock);
        check("stall_trip_single", 64'(bus.pwm_update), 64'd0);
        check("stall_dbg_fail", 64'(bus.debug_signals[7]), 64'd1);
        check("stall_dbg_idle", 64'(bus.debug_signals[2:0]), 64'd0);
        repeat (3) @(negedge clock);
        check("stall_fail_hold", 64'(bus.startup_fail), 64'd1);
        bus.enable_stall_chk = 1'b0;
        start_move(12'd100, 12'd10);
        check("stall_fail_clear", 64'(bus.startup_fail), 64'd0);
        wait_update("stall_restart", n);
        do_abort("stall_restart_abort");

        // Retarget mid-move restarts the profile.
        bus.profile = c_PROF_RAMP;
        start_move(12'd100, 12'd10);
        wait_update("retgt_start", n);
        do_read(12'd11);
        wait_update("retgt_read", n);
        check("retgt_read_ratio", 64'(bus.pwm_ratio), 64'd3);
        start_move(12'd200, 12'd11);
        wait_update("retgt_new", n);
        check("retgt_new_ratio", 64'(bus.pwm_ratio), 64'd2);
        check("retgt_new_dir", 64'(bus.pwm_direction), 64'd1);
        do_abort("retgt_abort");

        // Abort wins over a simultaneous read.
        bus.profile = c_PROF_OPEN;
        start_move(12'd100, 12'd10);
        wait_update("prio_start", n);
        bus.abort_angle   = 1'b1;
        bus.i2c_rd_done   = 1'b1;
        bus.current_angle = 12'd50;
        @(negedge clock);
        bus.abort_angle   = 1'b0;
        bus.i2c_rd_done   = 1'b0;
        check("prio_pulse", 64'(bus.pwm_update), 64'd1);
        check("prio_ratio", 64'(bus.pwm_ratio), 64'd0);
        cnt = 0;
        repeat (6) begin
            @(negedge clock);
            if (bus.pwm_update === 1'b1) cnt++;
        end
        check("prio_no_followup", 64'(cnt), 64'd0);

        // Dropping pwm_enable mid-move behaves as an abort.
        start_move(12'd100, 12'd10);
        wait_update("en_drop_start", n);
        bus.pwm_enable = 1'b0;
        @(negedge clock);
        check("en_drop_pulse", 64'(bus.pwm_update), 64'd1);
        check("en_drop_ratio", 64'(bus.pwm_ratio), 64'd0);
        check("en_drop_done", 64'(bus.angle_done), 64'd0);

        // Command while disabled is ignored.
        start_move(12'd100, 12'd10);
        cnt = 0;
        repeat (8) begin
            @(negedge clock);
            if (bus.pwm_update === 1'b1) cnt++;
        end
        check("disabled_ignored", 64'(cnt), 64'd0);
        check("disabled_idle", 64'(bus.debug_signals[2:0]), 64'd0);
        bus.pwm_enable = 1'b1;

        // pwm_done is only reflected in debug.
        bus.pwm_done = 1'b1;
        repeat (2) @(negedge clock);
        check("dbg_pwm_done", 64'(bus.debug_signals[9]), 64'd1);
        bus.pwm_done = 1'b0;

        // Reset mid-move abandons it silently.
        start_move(12'd100, 12'd10);
        wait_update("rst_mid_start", n);
        do_read(12'd20);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_mid_ratio", 64'(bus.pwm_ratio), 64'd0);
        check("rst_mid_dir", 64'(bus.pwm_direction), 64'd0);
        check("rst_mid_debug", 64'(bus.debug_signals), 64'd0);
        reset_n = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clock);
            if (bus.pwm_update === 1'b1 || bus.angle_done === 1'b1) cnt++;
        end
        check("rst_mid_no_pulse", 64'(cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/pid_controller.md
PID_CONTROLLER -- requirements
Module: pid_controller

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have reset_n  in  1  asynchronous, active-high reset (asserted = 1; codebase port name kept).
REQ-003 SHALL have target_angle  in  12  commanded encoder angle (0-4095); current_angle  in  12  encoder reading.
REQ-004 SHALL have pwm_enable  in  1  motion permitted; pwm_done  in  1  PWM ack, reflected in debug only, never gates control.
REQ-005 SHALL have i2c_rd_done  in  1  one-cycle strobe, current_angle freshly valid.
REQ-006 SHALL have angle_update  in  1  start-move pulse; abort_angle  in  1  stop request.
REQ-007 SHALL have profile  in  64  eight startup duty caps, step 0 = [63:56] … step 7 = [7:0].
REQ-008 SHALL have enable_stall_chk  in  1; kp  in  8  unsigned 4.4; ki  in  4  unsigned 0.4; kd  in  4  unsigned 0.4.
REQ-009 SHALL have startup_fail  out  1; angle_done  out  1; pwm_update  out  1; pwm_ratio  out  8; pwm_direction  out  1; debug_signals  out  16.

Function
REQ-010 SHALL implement states IDLE, CALC, UPDATE, WAIT, DONE.
REQ-011 IDLE: angle_update=1 and pwm_enable=1 -> latch target, clear integral, previous error, step counter and stall counter, clear startup_fail, go CALC; angle_update with pwm_enable=0 ignored.
REQ-012 CALC (one cycle): e = target - current as signed 13-bit; if e > 2047 subtract 4096, if e < -2048 add 4096 (shortest path).
REQ-013 CALC: if e == 0 go DONE; else acc = clamp(acc + e, -4096..4095), u = (kp*e + ki*acc + kd*(e - e_prev)) arithmetic-shifted right 4, e_prev = e.
REQ-014 CALC: pwm_direction = 1 when u >= 0 (angle increasing), else 0; duty = min(|u|, 255).
REQ-015 CALC: while step counter < 8, duty = min(duty, profile byte[step]); step counter saturates at 8.
REQ-016 UPDATE: drive pwm_ratio = duty, pulse pwm_update high exactly one cycle, go WAIT.
REQ-017 WAIT: i2c_rd_done=1 -> increment step counter if < 8, sample current_angle, go CALC; pwm_update therefore pulses 2 cycles after i2c_rd_done.
REQ-018 Stall check (enable_stall_chk=1, step counter < 8): count consecutive reads with current_angle unchanged; at 4 -> set startup_fail, pwm_ratio=0, one pwm_update pulse, go IDLE, no angle_done.
REQ-019 startup_fail SHALL stay set until next accepted angle_update or reset.
REQ-020 DONE: pwm_ratio=0, one-cycle pwm_update and one-cycle angle_done in same cycle, then IDLE.
REQ-021 abort_angle=1 or pwm_enable=0 in any non-IDLE state: next cycle pwm_ratio=0, one pwm_update pulse, IDLE, no angle_done; abort has priority over i2c_rd_done and done detection.
REQ-022 angle_update outside IDLE SHALL retarget: latch new target, restart step counter, keep direction, go CALC.
REQ-023 Outputs registered; pwm_ratio/pwm_direction hold between updates.
REQ-024 debug_signals: [2:0] state, [6:3] step counter, [7] startup_fail, [8] pwm_direction, [9] pwm_done, [15:10] |e| bits [5:0].

Reset
REQ-025 On reset: state IDLE; pwm_ratio=0, pwm_direction=0, pwm_update=0, angle_done=0, startup_fail=0, debug_signals=0; integral, error, counters cleared.
REQ-026 Reset mid-move SHALL abandon move with no pulses; target re-required via angle_update.

Verification
REQ-027 kp=0x12, ki=kd=0, target=100, current=10, profile={02..09}, angle_update -> pwm_update, pwm_ratio=2, direction=1.
REQ-028 Same move, 8 further i2c_rd_done with current incrementing -> caps 3..9 in turn, then uncapped duty = (18*e)>>4 (e=82 -> 92).
REQ-029 Reads continue until current=100 -> pwm_ratio=0, pwm_update and angle_done high together for one cycle, state IDLE.
REQ-030 target=10, current=4090 -> e=+16, direction=1; target=4090, current=10 -> direction=0.
REQ-031 enable_stall_chk=1, current constant over 4 reads -> startup_fail=1, pwm_ratio=0, no angle_done.
REQ-032 abort_angle pulsed mid-move -> pwm_ratio=0 with one pwm_update, IDLE, no angle_done.
